// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and types for the two-port memory arbiter.
//   PORT0/PORT1     port index values (also the encoding of last_win)
//   PRIO_RR/FIXED   values of the PRIO_MODE parameter
//   lock_state_t    lock FSM encoding (used when MEM_ARB_LOCK_EN is defined)
package mem_arb_pkg;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        LOCK0    = 2'b01,
        LOCK1    = 2'b10
    } lock_state_t;

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way winner select.
//   req0, req1   requests from port 0 / port 1
//   last_win     port granted most recently (round-robin history)
//   prio_mode    1 = fixed priority (port 0 wins ties), 0 = round-robin
//   lock_state   current lock owner; a locked port excludes the other
//   gnt[1:0]     one-hot grant (bit N = port N), all-zero when idle
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic        req0,
    input  logic        req1,
    input  logic        last_win,
    input  logic        prio_mode,
    input  lock_state_t lock_state,
    output logic [1:0]  gnt
);

    always_comb begin
        gnt = 2'b00;
        case (lock_state)
            LOCK0:   gnt = {1'b0, req0};
            LOCK1:   gnt = {req1, 1'b0};
            default: begin
                if (req0 && req1)
                    // Tie: fixed mode favours port 0; round-robin favours
                    // whichever port did not win last.
                    gnt = (prio_mode || last_win == PORT1) ? 2'b01 : 2'b10;
                else
                    gnt = {req1, req0};
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between port 0 (datapath)
// and port 1 (debug/loader). At most one access is issued per cycle; read
// data returns one cycle after grant.
//   CLOCK_50, RESETn              clock, async active-low reset
//   reqN/weN/addrN/wdataN         port N request (held until gntN)
//   gntN                          access issued this cycle (combinational)
//   rvalidN                       port N read completes this cycle
//   rdataN                        port N read data, captured at end of rvalid
//                                 cycle, held until the next port N read
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata   memory side
// Optional: define MEM_ARB_LOCK_EN to add lock0/lock1 inputs; a port granted
// with its lock bit set keeps exclusive ownership until it issues an
// unlocked access or drops its request for a cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic              CLOCK_50,
    input  logic              RESETn,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic FIXED = (PRIO_MODE == PRIO_FIXED);

    logic        last_win;
    logic [1:0]  pick;
    logic [1:0]  gnt;
    logic [1:0]  rd_pend;
    lock_state_t lock_state;

    arb_pick2 u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_win   (last_win),
        .prio_mode  (FIXED),
        .lock_state (lock_state),
        .gnt        (pick)
    );

    // Grants are combinational, so gate them with reset to keep the memory
    // strobes quiet while RESETn is low.
    assign gnt  = pick & {2{RESETn}};
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_read  = ~we0;
            mem_write = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt[1]) begin
            mem_read  = ~we1;
            mem_write = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    // rd_pend doubles as rvalid: set for the cycle after a read grant, during
    // which mem_rdata carries that read's data.
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            last_win <= PORT1;
            rd_pend  <= 2'b00;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            if (|gnt)
                last_win <= gnt[1] ? PORT1 : PORT0;
            rd_pend <= {gnt[1] & ~we1, gnt[0] & ~we0};
            if (rd_pend[0])
                rdata0 <= mem_rdata;
            if (rd_pend[1])
                rdata1 <= mem_rdata;
        end
    end

    assign rvalid0 = rd_pend[0];
    assign rvalid1 = rd_pend[1];

`ifdef MEM_ARB_LOCK_EN
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            lock_state <= UNLOCKED;
        end else begin
            case (lock_state)
                UNLOCKED: begin
                    if (gnt[0] && lock0)
                        lock_state <= LOCK0;
                    else if (gnt[1] && lock1)
                        lock_state <= LOCK1;
                end
                LOCK0: begin
                    if (!req0 || (gnt[0] && !lock0))
                        lock_state <= UNLOCKED;
                end
                LOCK1: begin
                    if (!req1 || (gnt[1] && !lock1))
                        lock_state <= UNLOCKED;
                end
                default: lock_state <= UNLOCKED;
            endcase
        end
    end
`else
    assign lock_state = UNLOCKED;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter, checked
// every cycle against a transaction-level model (shadow memory, expected
// winner per cycle, expected read returns). A second instance with fixed
// priority sees the same requests and has its grants checked.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int PRIO = 0;

    typedef struct packed {
        logic       idle;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       lock;
    } acc_t;

    logic       CLOCK_50 = 1'b0;
    logic       RESETn;
    logic       req0, we0, req1, we1, lock0, lock1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       gnt0_f, gnt1_f, rvalid0_f, rvalid1_f, mem_read_f, mem_write_f;
    logic [7:0] rdata0_f, rdata1_f, mem_addr_f, mem_wdata_f;

    always #5 CLOCK_50 = ~CLOCK_50;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(PRIO)) dut (
        .CLOCK_50(CLOCK_50), .RESETn(RESETn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
`ifdef MEM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(1)) dut_fix (
        .CLOCK_50(CLOCK_50), .RESETn(RESETn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_f), .rvalid0(rvalid0_f), .rdata0(rdata0_f),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_f), .rvalid1(rvalid1_f), .rdata1(rdata1_f),
`ifdef MEM_ARB_LOCK_EN
        .lock0(1'b0), .lock1(1'b0),
`endif
        .mem_read(mem_read_f), .mem_write(mem_write_f), .mem_addr(mem_addr_f),
        .mem_wdata(mem_wdata_f), .mem_rdata(8'h00)
    );

    // Environment memory: synchronous read, write lands at the edge.
    logic [7:0] mem [256];
    always @(posedge CLOCK_50) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr];
    end

    // Requester state and reference model
    acc_t       q0[$], q1[$];
    acc_t       cur [2];
    logic       act [2];
    logic [1:0] glast;
    logic [7:0] shadow [256];
    logic       lw;
    logic [1:0] lk;
    logic       pend [2];
    logic [7:0] pend_d [2];
    logic [7:0] exp_rd [2];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Who should win given the requests, the lock owner and arbitration history.
    function automatic logic [1:0] exp_pick(input logic r0, input logic r1);
        if (lk == 2'd1) return r0 ? 2'b01 : 2'b00;
        if (lk == 2'd2) return r1 ? 2'b10 : 2'b00;
        if (r0 && r1) begin
            if (PRIO == 1) return 2'b01;
            return (lw == 1'b1) ? 2'b01 : 2'b10;
        end
        if (r0) return 2'b01;
        if (r1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic drive();
        req0 = act[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata; lock0 = cur[0].lock;
        req1 = act[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata; lock1 = cur[1].lock;
    endtask

    task automatic model_reset();
        lw = 1'b1;
        lk = 2'd0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pend_d[p] = 8'h00; exp_rd[p] = 8'h00;
        end
    endtask

    // One cycle, entered right at a falling edge.
    task automatic body();
        logic [1:0] g;
        acc_t       s;
        acc_t       e;
        for (int p = 0; p < 2; p++) begin
            if (act[p] && glast[p]) begin act[p] = 1'b0; cur[p] = '0; end
            if (!act[p]) begin
                if (p == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    if (!e.idle) begin cur[0] = e; act[0] = 1'b1; end
                end else if (p == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    if (!e.idle) begin cur[1] = e; act[1] = 1'b1; end
                end
            end
        end
        drive();
        #1;
        g = exp_pick(act[0], act[1]);
        s = g[0] ? cur[0] : (g[1] ? cur[1] : acc_t'('0));
        chk("gnt0", 32'(gnt0), 32'(g[0]));
        chk("gnt1", 32'(gnt1), 32'(g[1]));
        chk("mem_read",  32'(mem_read),  32'((g != 2'b00) && !s.we));
        chk("mem_write", 32'(mem_write), 32'((g != 2'b00) && s.we));
        chk("mem_addr",  32'(mem_addr),  32'(s.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(s.wdata));
        chk("rvalid0", 32'(rvalid0), 32'(pend[0]));
        chk("rvalid1", 32'(rvalid1), 32'(pend[1]));
        chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
        chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
        chk("fix_gnt0", 32'(gnt0_f), 32'(act[0]));
        chk("fix_gnt1", 32'(gnt1_f), 32'(act[1] && !act[0]));

        // Effects of the upcoming rising edge
        for (int p = 0; p < 2; p++) begin
            if (pend[p]) exp_rd[p] = pend_d[p];
            pend[p] = 1'b0;
            if (g[p] && !cur[p].we) begin pend[p] = 1'b1; pend_d[p] = shadow[cur[p].addr]; end
            if (g[p] && cur[p].we) shadow[cur[p].addr] = cur[p].wdata;
        end
`ifdef MEM_ARB_LOCK_EN
        if (lk == 2'd0) begin
            if (g[0] && cur[0].lock) lk = 2'd1;
            else if (g[1] && cur[1].lock) lk = 2'd2;
        end else if (lk == 2'd1) begin
            if (!act[0] || (g[0] && !cur[0].lock)) lk = 2'd0;
        end else begin
            if (!act[1] || (g[1] && !cur[1].lock)) lk = 2'd0;
        end
`endif
        if (g != 2'b00) lw = g[1];
        glast = g;
    endtask

    task automatic cycle();
        @(negedge CLOCK_50);
        body();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q0.size() != 0 || q1.size() != 0 || (act[0] && !glast[0]) || (act[1] && !glast[1])) begin
            cycle();
            n++;
            if (n > 300) begin
                chk("drain_timeout", 32'(1), 32'(0));
                break;
            end
        end
        cycle();
        cycle();
    endtask

    // Assert reset just before the next rising edge, hold it, then release at
    // a falling edge and continue with that cycle.
    task automatic do_reset();
        #1 RESETn = 1'b0;
        #1;
        model_reset();
        repeat (2) begin
            chk("rst_gnt0", 32'(gnt0), 32'(0));
            chk("rst_gnt1", 32'(gnt1), 32'(0));
            chk("rst_mem_read", 32'(mem_read), 32'(0));
            chk("rst_mem_write", 32'(mem_write), 32'(0));
            chk("rst_rvalid0", 32'(rvalid0), 32'(0));
            chk("rst_rvalid1", 32'(rvalid1), 32'(0));
            chk("rst_rdata0", 32'(rdata0), 32'(0));
            chk("rst_rdata1", 32'(rdata1), 32'(0));
            @(posedge CLOCK_50);
            #1;
        end
        @(negedge CLOCK_50);
        RESETn = 1'b1;
        body();
    endtask

    function automatic acc_t mk(input logic we, input logic [7:0] a, input logic [7:0] d, input logic lock);
        acc_t e;
        e.idle = 1'b0; e.we = we; e.addr = a; e.wdata = d; e.lock = lock;
        return e;
    endfunction

    function automatic acc_t idle_e();
        acc_t e;
        e = '0;
        e.idle = 1'b1;
        return e;
    endfunction

    function automatic acc_t rnd_e();
        acc_t e;
        if ($urandom_range(0, 2) == 0) return idle_e();
        e = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), 1'b0);
`ifdef MEM_ARB_LOCK_EN
        e.lock = ($urandom_range(0, 5) == 0);
`endif
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            shadow[i] = mem[i];
        end
        for (int p = 0; p < 2; p++) begin cur[p] = '0; act[p] = 1'b0; end
        glast = 2'b00;
        RESETn = 1'b0;
        drive();
        model_reset();
        // Reset state with requests present
        act[0] = 1'b1; act[1] = 1'b1;
        drive();
        #2;
        chk("init_gnt0", 32'(gnt0), 32'(0));
        chk("init_gnt1", 32'(gnt1), 32'(0));
        chk("init_mem_read", 32'(mem_read), 32'(0));
        chk("init_rvalid0", 32'(rvalid0), 32'(0));
        chk("init_rdata1", 32'(rdata1), 32'(0));
        act[0] = 1'b0; act[1] = 1'b0;
        drive();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESETn = 1'b1;
        // First tie after reset: port 0 must win
        q0.push_back(mk(1'b0, 8'h05, 8'h00, 1'b0));
        q1.push_back(mk(1'b0, 8'h06, 8'h00, 1'b0));
        body();
        drain();

        // Port 1 write 0xA5 to 0x10 then read it back
        q1.push_back(mk(1'b1, 8'h10, 8'hA5, 1'b0));
        q1.push_back(mk(1'b0, 8'h10, 8'h00, 1'b0));
        drain();
        chk("wr_rd_a5", 32'(rdata1), 32'(8'hA5));

        // Round-robin contention on preloaded 0x11 / 0x22
        q0.push_back(mk(1'b1, 8'h00, 8'h11, 1'b0));
        q1.push_back(mk(1'b1, 8'h01, 8'h22, 1'b0));
        drain();
        repeat (6) begin
            q0.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0));
            q1.push_back(mk(1'b0, 8'h01, 8'h00, 1'b0));
        end
        drain();
        chk("rr_rdata0", 32'(rdata0), 32'(8'h11));
        chk("rr_rdata1", 32'(rdata1), 32'(8'h22));

        // Idle gaps between single accesses
        q0.push_back(mk(1'b0, 8'h01, 8'h00, 1'b0));
        repeat (3) q0.push_back(idle_e());
        q0.push_back(mk(1'b1, 8'h07, 8'h3C, 1'b0));
        repeat (3) q0.push_back(idle_e());
        q0.push_back(mk(1'b0, 8'h07, 8'h00, 1'b0));
        drain();

        // Reset while a read is in flight
        q0.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0));
        cycle();
        do_reset();
        q0.push_back(mk(1'b0, 8'h02, 8'h00, 1'b0));
        q1.push_back(mk(1'b0, 8'h03, 8'h00, 1'b0));
        drain();

`ifdef MEM_ARB_LOCK_EN
        // Port 0 holds a lock over three accesses; port 1 waits
        q0.push_back(mk(1'b1, 8'h02, 8'h5A, 1'b1));
        q0.push_back(mk(1'b0, 8'h02, 8'h00, 1'b1));
        q0.push_back(mk(1'b1, 8'h03, 8'hC3, 1'b0));
        q1.push_back(idle_e());
        repeat (3) q1.push_back(mk(1'b0, 8'h02, 8'h00, 1'b0));
        drain();
        chk("lock_rdata1", 32'(rdata1), 32'(8'h5A));
`endif

        // Random traffic
        repeat (600) begin
            if (q0.size() < 2) q0.push_back(rnd_e());
            if (q1.size() < 2) q1.push_back(rnd_e());
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 256x8 synchronous-read program/data memory between two requesters: port 0 (processor datapath: fetch, LOAD and STORE) and port 1 (debug/loader: switch-driven program load and memory inspect).
- Sits between the requesters and the memory, and drives its MemRead, MemWrite, ADDR and Data_in.
- Grants at most one access per cycle and returns read data one cycle after grant.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- RESETn  in  1  asynchronous active-low reset.
- req0  in  1  port 0 access request; held until gnt0.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 access issued this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: the same set of signals for port 1.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_W  to memory ADDR.
- mem_wdata  out  DATA_W  to memory Data_in.
- mem_rdata  in  DATA_W  from memory Data_out; valid the cycle after a read is issued.

Behaviour:
- Reset (asynchronous, RESETn=0):
  - rvalid0/1=0, rdata0/1=0, pending-read tags cleared.
  - Round-robin pointer last_win=1, so port 0 wins the first tie.
  - gnt0/1, mem_read and mem_write are forced to 0 while RESETn=0.
- Grant decision is combinational in the same cycle as the request:
  - Only one requester asserting: that port is granted.
  - Both asserting, PRIO_MODE=0: grant the port not equal to last_win.
  - Both asserting, PRIO_MODE=1: grant port 0.
  - Neither asserting: no grant; all mem_* outputs idle, mem_addr/mem_wdata = 0.
- Memory drive in a grant cycle: mem_addr and mem_wdata come from the winning port; mem_write=we; mem_read=~we. Exactly one of mem_read/mem_write is high.
- last_win updates at the clock edge ending a grant cycle, only when a grant occurred.
- Handshake:
  - The requester holds req/we/addr/wdata stable until it sees gnt high.
  - gnt is high for exactly one cycle per access.
  - If req is still high in the cycle after gnt, that is a new request.
- Read return:
  - A read granted in cycle t gives rvalidN=1 in cycle t+1, with rdataN=mem_rdata registered at the end of t+1.
  - rdataN holds its value until the next read for that port.
  - Writes produce no rvalid.
- Throughput and fairness:
  - Back-to-back accesses, one per cycle, with any read/write mix; no bubble is needed.
  - With both ports continuously requesting under PRIO_MODE=0, grants alternate 0,1,0,1.
- Reset mid-read: the pending rvalid is discarded and is not re-issued after reset.
- Write and read to the same address in consecutive cycles: the read returns the new data (memory is write-first across cycles).

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- When defined, ports gain an input lock0 and lock1 (1 bit each).
  - A port granted with lockN=1 enters state LOCKN; the other port is then denied grants until the owner issues a granted access with lockN=0, or deasserts req for a cycle.
  - Lock FSM: UNLOCKED -> LOCK0 / LOCK1 -> UNLOCKED.
  - Reset returns the FSM to UNLOCKED.
  - Lock overrides PRIO_MODE.
- When not defined: no lock ports and no lock state; pure arbitration as specified above.

Decomposition:
- Shared package mem_arb_pkg:
  - Port index constants PORT0=0, PORT1=1.
  - PRIO_RR=0, PRIO_FIXED=1.
  - Lock-state encodings UNLOCKED=2'b00, LOCK0=2'b01, LOCK1=2'b10.
- Sub-module arb_pick2: combinational two-way winner select from (req0, req1, last_win, prio_mode, lock_state), producing a one-hot grant. The arbiter instantiates it once.

Test Plan:
- Reset: assert RESETn=0 mid-read, then release -> rvalid0/1 stay 0, no mem strobes during reset, first tie goes to port 0.
- Single write then read: port 1 writes 0xA5 to 0x10 in cycle 1, then reads 0x10 in cycle 2 -> gnt1 in both cycles, rvalid1 in cycle 3 with rdata1=0xA5.
- Contention, round-robin: both ports request reads continuously (port 0 at 0x00, port 1 at 0x01, memory preloaded 0x11/0x22) -> grants alternate 0,1,0,1; rdata0=0x11, rdata1=0x22, each one cycle after its gnt.
- Fixed priority: PRIO_MODE=1, both requesting for 4 cycles -> gnt0 all 4 cycles, gnt1 only after req0 drops.
- Idle gaps: req pulses separated by 3 idle cycles -> mem_read/mem_write 0 and mem_addr 0 in every idle cycle; no spurious rvalid.
- MEM_ARB_LOCK_EN: port 0 locks for 3 accesses while port 1 requests throughout -> gnt1 withheld until port 0 issues its access with lock0=0; gnt1 asserted the following cycle.
